// File: rtl/mux_n_reg.sv
// ============================================================================
// mux_n_reg : N-to-1 registered stream mux, explicit or round-robin select
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mux_n_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MODE,
  input  logic [SEL_W-1:0]        SELECT,
  input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
  input  logic [NUM_IN-1:0]       IN_VALID,
  output logic [NUM_IN-1:0]       IN_READY,
  output logic [WIDTH-1:0]        OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [SEL_W-1:0]        OUT_CHAN
);

  localparam logic [SEL_W-1:0] C_PTR_RST = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;

  logic             w_cand_found;
  logic [SEL_W-1:0] w_cand;
  logic [WIDTH-1:0] w_cand_data;
  logic             w_load_en;
  logic             w_xfer;

  // An out-of-range or unknown SELECT matches no channel, so no candidate.
  always_comb begin
    w_cand_found = 1'b0;
    w_cand       = '0;
    if (!MODE) begin
      for (int c = 0; c < NUM_IN; c++) begin
        if (SELECT == SEL_W'(c) && IN_VALID[c]) begin
          w_cand_found = 1'b1;
          w_cand       = SEL_W'(c);
        end
      end
    end else begin
      // Upward search from PTR+1 with wrap: channels above PTR first, then 0..PTR.
      for (int c = 0; c < NUM_IN; c++) begin
        if (!w_cand_found && IN_VALID[c] && SEL_W'(c) > ptr_q) begin
          w_cand_found = 1'b1;
          w_cand       = SEL_W'(c);
        end
      end
      for (int c = 0; c < NUM_IN; c++) begin
        if (!w_cand_found && IN_VALID[c] && SEL_W'(c) <= ptr_q) begin
          w_cand_found = 1'b1;
          w_cand       = SEL_W'(c);
        end
      end
    end
  end

  always_comb begin
    w_cand_data = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      if (w_cand == SEL_W'(c)) begin
        w_cand_data = IN_DATA[c*WIDTH +: WIDTH];
      end
    end
  end

  // RESET gates the strobe so no handshake is offered while held in reset.
  assign w_load_en = !out_valid_q || OUT_READY;
  assign w_xfer    = w_cand_found && w_load_en && RESET;

  always_comb begin
    IN_READY = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      if (w_xfer && w_cand == SEL_W'(c)) begin
        IN_READY[c] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = w_cand_data;
      out_chan_d  = w_cand;
      ptr_d       = w_cand;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr_q       <= C_PTR_RST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CHAN  = out_chan_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_reg.sv
// ============================================================================
// tb_mux_n_reg : directed self-checking bench for mux_n_reg
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mux_n_reg;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  sel4;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_chan;

  logic [3:0]  w4_in_ready;
  logic [7:0]  w4_out_data;
  logic        w4_out_valid;
  logic [3:0]  w4_out_chan;

  int n_vec;
  int n_err;

  mux_n_reg #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) dut (
    .CLK(clk), .RESET(reset), .MODE(mode), .SELECT(sel),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_CHAN(out_chan)
  );

  mux_n_reg #(.WIDTH(8), .NUM_IN(4), .SEL_W(4)) dut_w4 (
    .CLK(clk), .RESET(reset), .MODE(mode), .SELECT(sel4),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(w4_in_ready),
    .OUT_DATA(w4_out_data), .OUT_VALID(w4_out_valid), .OUT_READY(out_ready),
    .OUT_CHAN(w4_out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".chan"},  32'(out_chan),  32'(c));
  endtask

  localparam logic [7:0] D0 = 8'h11, D1 = 8'h22, D2 = 8'hA5, D3 = 8'h3C;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    sel4      = 4'd0;
    in_data   = {D3, D2, D1, D0};
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Held in reset with every channel valid: nothing may be offered.
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    tick();
    tick();
    reset    = 1'b1;
    mode     = 1'b0;
    in_valid = 4'b0000;
    tick();

    // Explicit select of channel 2.
    sel      = 2'd2;
    in_valid = 4'b0100;
    #1;
    chk("sel2.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("sel2", 1'b1, D2, 2'd2);
    in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("drain.valid", 32'(out_valid), 32'h0);

    // Out-of-range select on the wide-select build; main DUT takes channel 3.
    sel      = 2'd3;
    sel4     = 4'd5;
    in_valid = 4'b1111;
    #1;
    chk("oor.w4_in_ready", 32'(w4_in_ready), 32'h0);
    chk("sel3.in_ready", 32'(in_ready), 32'b1000);
    tick();
    chk("oor.w4_valid", 32'(w4_out_valid), 32'h0);
    chk_out("sel3", 1'b1, D3, 2'd3);
    in_valid = 4'b0000;
    tick();
    chk("drain2.valid", 32'(out_valid), 32'h0);

    // Round-robin from PTR=3 with all valid: 0,1,2,3,0 back-to-back.
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("rr.first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] ec;
      logic [7:0] ed;
      ec = 2'(k % 4);
      ed = in_data[ec*8 +: 8];
      tick();
      chk_out($sformatf("rr%0d", k), 1'b1, ed, ec);
    end

    // Backpressure: register frozen on channel 0 while inputs wander.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mode     = k[0];
      sel      = 2'(k + 1);
      in_valid = 4'(4'b0101 << k);
      #1;
      chk($sformatf("hold%0d.in_ready", k), 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("hold%0d", k), 1'b1, D0, 2'd0);
    end
    out_ready = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("release", 1'b1, D1, 2'd1);

    // Explicit detour to channel 3, then round-robin resumes after it.
    mode = 1'b0;
    sel  = 2'd3;
    #1;
    chk("detour.in_ready", 32'(in_ready), 32'b1000);
    tick();
    chk_out("detour", 1'b1, D3, 2'd3);
    mode = 1'b1;
    #1;
    chk("resume.in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("resume", 1'b1, D0, 2'd0);

    // No valid inputs in round-robin: drains, pointer stays at 0.
    in_valid = 4'b0000;
    #1;
    chk("none.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("none.valid", 32'(out_valid), 32'h0);
    in_valid = 4'b1001;
    #1;
    chk("after_none.in_ready", 32'(in_ready), 32'b1000);
    tick();
    chk_out("after_none", 1'b1, D3, 2'd3);

    // Mid-cycle async reset discards the held 8'h3C word.
    out_ready = 1'b0;
    #2;
    chk_out("pre_rst", 1'b1, D3, 2'd3);
    reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 2'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'h0);
    #2;
    reset     = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1001;
    out_ready = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("post_rst0", 1'b1, D0, 2'd0);
    #1;
    chk("post_rst.in_ready2", 32'(in_ready), 32'b1000);
    tick();
    chk_out("post_rst3", 1'b1, D3, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_n_reg.md
MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel in bits.
REQ-002 SHALL have parameter NUM_IN, default 4: number of input channels, range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2: select width, with ceil(log2(NUM_IN)) <= SEL_W.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port MODE, input, 1 bit: 0 = explicit select, 1 = round-robin.
REQ-007 SHALL have port SELECT, input, SEL_W bits: channel index used in explicit mode.
REQ-008 SHALL have port IN_DATA, input, NUM_IN*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port IN_VALID, input, NUM_IN bits: per-channel data-valid.
REQ-010 SHALL have port IN_READY, output, NUM_IN bits: per-channel accept strobe, combinational.
REQ-011 SHALL have port OUT_DATA, output, WIDTH bits: registered selected data.
REQ-012 SHALL have port OUT_VALID, output, 1 bit: OUT_DATA holds an undelivered word.
REQ-013 SHALL have port OUT_READY, input, 1 bit: downstream accepts OUT_DATA this cycle.
REQ-014 SHALL have port OUT_CHAN, output, SEL_W bits: index of the channel that supplied OUT_DATA.

Function
REQ-015 SHALL hold a one-word output register, with load enable = !OUT_VALID || OUT_READY (register empty, or draining this cycle).
REQ-016 SHALL compute a candidate each cycle: explicit mode, channel SELECT if IN_VALID[SELECT]=1; round-robin mode, the first channel with IN_VALID=1 searching upward from (PTR+1) mod NUM_IN.
REQ-017 SHALL drive IN_READY[c]=1 only for the candidate c, only when load enable=1, and all other bits 0 (at most one hot).
REQ-018 SHALL, on a transfer (IN_VALID[c] && IN_READY[c]), load OUT_DATA=channel c data and OUT_CHAN=c, set OUT_VALID=1, and set PTR=c, giving 1-cycle latency from acceptance to OUT_VALID.
REQ-019 SHALL clear OUT_VALID when OUT_READY=1 and no new transfer occurs in that cycle.
REQ-020 SHALL, on a simultaneous drain and transfer, keep OUT_VALID=1 and replace the word with no bubble, sustaining one word per cycle.
REQ-021 SHALL hold OUT_DATA and OUT_CHAN stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 SHALL, in explicit mode with SELECT >= NUM_IN or SELECT containing X/Z, produce no candidate (IN_READY all 0) and leave the output register unchanged.
REQ-023 SHALL update PTR on every transfer in both modes, so a switch to round-robin resumes after the last-served channel.
REQ-024 SHALL apply MODE and SELECT changes in the same cycle as the change (both are combinational inputs to candidate selection), with no effect on an already-registered word.
REQ-025 SHALL, in round-robin mode with no IN_VALID set, produce no candidate and leave PTR unchanged.

Reset
REQ-026 SHALL, while RESET=0, asynchronously force OUT_VALID=0, OUT_DATA=0, OUT_CHAN=0, PTR=NUM_IN-1, and IN_READY=0.
REQ-027 SHALL discard an undelivered word when reset is asserted mid-operation.
REQ-028 SHALL make the first round-robin grant after reset go to channel 0 if it is valid.

Verification
REQ-029 SHALL be verified as: explicit mode, SELECT=2, IN_VALID=4'b0100, ch2=8'hA5, OUT_READY=1 -> IN_READY=4'b0100; next cycle OUT_VALID=1, OUT_DATA=8'hA5, OUT_CHAN=2.
REQ-030 SHALL be verified as: round-robin, IN_VALID=4'b1111 held, OUT_READY=1 -> OUT_CHAN sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
REQ-031 SHALL be verified as: OUT_VALID=1, OUT_READY=0 for 3 cycles with inputs changing -> OUT_DATA/OUT_CHAN constant and IN_READY=0; OUT_READY=1 then gives the next word one cycle later.
REQ-032 SHALL be verified as: explicit mode, SELECT=4'd5 with NUM_IN=4 (SEL_W=4 build), all valid -> IN_READY=0 and OUT_VALID stays 0.
REQ-033 SHALL be verified as: RESET pulsed low mid-cycle while OUT_VALID=1, OUT_DATA=8'h3C -> OUT_VALID=0 and OUT_DATA=0 immediately, without waiting for a clock; after release with IN_VALID=4'b1001 in round-robin -> first grant is channel 0, then channel 3.
REQ-034 SHALL be verified as: round-robin serving channel 1, then MODE=0, SELECT=3 for one transfer, then MODE=1 with all valid -> next grant is channel 0 (PTR=3).
